// File: rtl/intt_controller.sv
// intt_controller: in-place inverse NTT sequencer for one Gentleman-Sande butterfly.
// Issues one butterfly per cycle, drains the pipeline between stages and
// generates delayed in-place write-back addresses.
module intt_controller #(
    parameter int unsigned LOG_N      = 12,
    parameter int unsigned BF_LATENCY = 10,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       stage,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    output logic [LOG_N-1:0] tw_addr,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b
);

    localparam int unsigned N    = 1 << LOG_N;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned L    = RD_LATENCY + BF_LATENCY;
    localparam int unsigned DW   = $clog2(L) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    state_t           state, state_n;
    logic [3:0]       s, s_n;
    logic [LOG_N-1:0] c, c_n;
    logic [DW-1:0]    d, d_n;

    logic [LOG_N-1:0] t_n, i_n, k_n, a_n, b_n, tw_n;
    logic             issue_n;

    logic             v_line [L];
    logic [LOG_N-1:0] a_line [L];
    logic [LOG_N-1:0] b_line [L];

    // Next-state and counter logic.
    always_comb begin
        state_n = state;
        s_n     = s;
        c_n     = c;
        d_n     = d;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_ISSUE;
                    s_n     = '0;
                    c_n     = '0;
                end
            end
            ST_ISSUE: begin
                if (c == LOG_N'(HALF - 1)) begin
                    state_n = ST_DRAIN;
                    c_n     = '0;
                    d_n     = '0;
                end else begin
                    c_n = c + LOG_N'(1);
                end
            end
            ST_DRAIN: begin
                if (d == DW'(L - 1)) begin
                    if (s == 4'(LOG_N - 1)) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_ISSUE;
                        s_n     = s + 4'd1;
                    end
                end else begin
                    d_n = d + DW'(1);
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Butterfly addresses for the upcoming cycle; forced to 0 outside ISSUE.
    always_comb begin
        issue_n = (state_n == ST_ISSUE);
        t_n     = LOG_N'(1) << s_n;
        i_n     = c_n >> s_n;
        k_n     = c_n & (t_n - LOG_N'(1));
        a_n     = (i_n << (s_n + 4'd1)) | k_n;
        b_n     = a_n + t_n;
        tw_n    = LOG_N'(N >> (s_n + 4'd1)) + i_n;
        if (!issue_n) begin
            a_n  = '0;
            b_n  = '0;
            tw_n = '0;
        end
    end

    // State, counters and registered read-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            s         <= '0;
            c         <= '0;
            d         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            state     <= state_n;
            s         <= s_n;
            c         <= c_n;
            d         <= d_n;
            busy      <= (state_n == ST_ISSUE) || (state_n == ST_DRAIN);
            done      <= (state_n == ST_DONE);
            stage     <= s_n;
            rd_en     <= issue_n;
            rd_addr_a <= a_n;
            rd_addr_b <= b_n;
            tw_addr   <= tw_n;
        end
    end

    // Write-back shift line: each read reappears as an in-place write L cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < int'(L); j++) begin
                v_line[j] <= 1'b0;
                a_line[j] <= '0;
                b_line[j] <= '0;
            end
        end else begin
            v_line[0] <= rd_en;
            a_line[0] <= rd_addr_a;
            b_line[0] <= rd_addr_b;
            for (int j = 1; j < int'(L); j++) begin
                v_line[j] <= v_line[j-1];
                a_line[j] <= a_line[j-1];
                b_line[j] <= b_line[j-1];
            end
        end
    end

    assign wr_en     = v_line[L-1];
    assign wr_addr_a = a_line[L-1];
    assign wr_addr_b = b_line[L-1];

endmodule
